// File: rtl/counter_seq_ctrl_pkg.sv
// Shared definitions for the counter sequencing controller: FSM encoding,
// direction encoding and the wrap-counter width.
package counter_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_RUN  = 2'b10,
      ST_DONE = 2'b11
   } state_e;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam int REP_W = 8;

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Job-side handshake plus the counter_4bit control/status pins.
// master = job issuer / counter side, slave = sequencing controller.
interface counter_seq_ctrl_if;

   logic       start;
   logic       dir;
   logic [3:0] init_val;
   logic       step_en;
   logic       abort;
   logic       ready;
   logic       busy;
   logic       done;
   logic       aborted;

   logic       load;
   logic [3:0] par_in;
   logic       up_cnt_en;
   logic       down_cnt_en;
   logic       carry_out;

   modport master (
      output start, dir, init_val, step_en, abort, carry_out,
      input  ready, busy, done, aborted, load, par_in, up_cnt_en, down_cnt_en
   );

   modport slave (
      input  start, dir, init_val, step_en, abort, carry_out,
      output ready, busy, done, aborted, load, par_in, up_cnt_en, down_cnt_en
   );

endinterface

// File: rtl/counter_4bit.sv
// 4-bit up/down counter with parallel load; carry_out flags the cycle in
// which an enabled step wraps (15->0 up, 0->15 down).
module counter_4bit (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] par_in,
   input  logic       up_cnt_en,
   input  logic       down_cnt_en,
   output logic [3:0] count,
   output logic       carry_out
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)             count <= '0;
      else if (load)        count <= par_in;
      else if (up_cnt_en)   count <= count + 4'd1;
      else if (down_cnt_en) count <= count - 4'd1;
   end

   assign carry_out = !load && ((up_cnt_en && count == 4'd15) ||
                                (!up_cnt_en && down_cnt_en && count == 4'd0));

endmodule

// File: rtl/counter_seq_ctrl_wrap.sv
// wrap_event_counter: counts carry events within one job and flags when the
// current event is the last one the job asked for.
module wrap_event_counter
   import counter_seq_ctrl_pkg::*;
#(
   parameter int REPEAT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic last_event
);

   logic [REP_W-1:0] rep_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)     rep_cnt <= '0;
      else if (clr) rep_cnt <= '0;
      else if (inc) rep_cnt <= rep_cnt + 1'b1;
   end

   assign last_event = (rep_cnt == REP_W'(REPEAT - 1));

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for counter_4bit: loads a start value, enables
// counting in the latched direction and finishes after REPEAT wraps.
module counter_seq_ctrl
   import counter_seq_ctrl_pkg::*;
#(
   parameter int REPEAT = 1
) (
   input  logic               clk,
   input  logic               rst,
   counter_seq_ctrl_if.slave  bus
);

   state_e     state_q, state_d;
   logic       dir_q;
   logic [3:0] init_q;
   logic       aborted_q, aborted_d;
   logic       last_event, rep_clr, rep_inc, wrap;

   // A carry only counts when this block actually enabled the step.
   assign wrap    = (state_q == ST_RUN) && bus.step_en && bus.carry_out;
   assign rep_clr = (state_q == ST_LOAD);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         aborted_q <= aborted_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dir_q  <= DIR_DOWN;
         init_q <= '0;
      end else if (state_q == ST_IDLE && bus.start) begin
         dir_q  <= bus.dir;
         init_q <= bus.init_val;
      end
   end

   always_comb begin
      state_d   = state_q;
      aborted_d = 1'b0;
      rep_inc   = 1'b0;
      case (state_q)
         ST_IDLE: if (bus.start) state_d = ST_LOAD;
         ST_LOAD: begin
            if (bus.abort) begin
               state_d   = ST_IDLE;
               aborted_d = 1'b1;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // Abort wins over a coinciding final wrap.
            if (bus.abort) begin
               state_d   = ST_IDLE;
               aborted_d = 1'b1;
            end else if (wrap) begin
               if (last_event) state_d = ST_DONE;
               else            rep_inc = 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   wrap_event_counter #(.REPEAT(REPEAT)) u_wrap (
      .clk        (clk),
      .rst        (rst),
      .clr        (rep_clr),
      .inc        (rep_inc),
      .last_event (last_event)
   );

   assign bus.ready       = (state_q == ST_IDLE);
   assign bus.busy        = (state_q == ST_LOAD) || (state_q == ST_RUN);
   assign bus.done        = (state_q == ST_DONE);
   assign bus.aborted     = aborted_q;
   assign bus.load        = (state_q == ST_LOAD);
   assign bus.par_in      = (state_q == ST_LOAD) ? init_q : 4'd0;
   assign bus.up_cnt_en   = (state_q == ST_RUN) && bus.step_en && (dir_q == DIR_UP);
   assign bus.down_cnt_en = (state_q == ST_RUN) && bus.step_en && (dir_q == DIR_DOWN);

endmodule
